alu_result_collector: RTL and testbench

Downstream stage of the ALU's four function units (arithmetic, logic, compare, shift). Each cycle it takes the registered `*_out`/`*_flag` pairs and tags the one valid result with its source unit. It queues tagged results in a small FIFO and presents them to the consumer (output register / UART TX) over a valid/ready handshake. Protocol violations are detected and latched as sticky errors: multiple units flagging in one cycle, or a push into a full queue.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_sync_fifo.sv | 61 ++++++
 rtl/alu_result_collector.sv | 121 ++++++++++++
 tb/tb_alu_result_collector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-unit tags and the tagged result entry.
package alu_pkg;

  localparam int TAG_W      = 2;
  localparam int ALU_DATA_W = 8;

  typedef enum logic [TAG_W-1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_tag_e;

  typedef struct packed {
    unit_tag_e               tag;
    logic [ALU_DATA_W-1:0]   data;
  } alu_entry_t;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a push in the same cycle.
module alu_sync_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = TAG_W + ALU_DATA_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  // Head is forced to zero while empty so the outputs have a defined reset value.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Tags the one valid ALU unit result per cycle, queues it, and flags protocol errors.
// Optional build macro ALU_COLLECT_PARITY_EN adds a stored even-parity bit and res_parity.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   arith_out,
  input  logic                    arith_flag,
  input  logic [DATA_WIDTH-1:0]   logic_out,
  input  logic                    logic_flag,
  input  logic [DATA_WIDTH-1:0]   cmp_out,
  input  logic                    cmp_flag,
  input  logic [DATA_WIDTH-1:0]   shift_out,
  input  logic                    shift_flag,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic [1:0]              res_tag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    collision_err,
  output logic                    overflow_err,
  input  logic                    err_clr
`ifdef ALU_COLLECT_PARITY_EN
  ,output logic                   res_parity
`endif
);

  localparam int ENTRY_W = TAG_W + DATA_WIDTH;
`ifdef ALU_COLLECT_PARITY_EN
  localparam int FIFO_W = ENTRY_W + 1;

  function automatic logic even_parity(input logic [ENTRY_W-1:0] v);
    return ^v;
  endfunction
`else
  localparam int FIFO_W = ENTRY_W;
`endif

  logic [3:0]            flags;
  unit_tag_e             sel_tag;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ENTRY_W-1:0]    sel_entry;
  logic [FIFO_W-1:0]     fifo_din, fifo_dout;
  logic                  push_req, pop_req, collision_now, overflow_now;
  logic                  fifo_full, fifo_empty;
  logic                  collision_err_q, collision_err_d;
  logic                  overflow_err_q, overflow_err_d;

  assign flags = {arith_flag, logic_flag, cmp_flag, shift_flag};

  always_comb begin
    sel_tag  = UNIT_SHIFT;
    sel_data = shift_out;
    if (arith_flag) begin
      sel_tag  = UNIT_ARITH;
      sel_data = arith_out;
    end else if (logic_flag) begin
      sel_tag  = UNIT_LOGIC;
      sel_data = logic_out;
    end else if (cmp_flag) begin
      sel_tag  = UNIT_CMP;
      sel_data = cmp_out;
    end
  end

  assign sel_entry = {sel_tag, sel_data};
`ifdef ALU_COLLECT_PARITY_EN
  assign fifo_din = {even_parity(sel_entry), sel_entry};
`else
  assign fifo_din = sel_entry;
`endif

  // A new error in the clearing cycle wins over err_clr.
  always_comb begin
    push_req        = |flags;
    pop_req         = ~fifo_empty & res_ready;
    collision_now   = (flags & (flags - 4'd1)) != 4'd0;
    overflow_now    = push_req & fifo_full & ~pop_req;
    collision_err_d = (collision_err_q & ~err_clr) | collision_now;
    overflow_err_d  = (overflow_err_q & ~err_clr) | overflow_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_err_q <= 1'b0;
      overflow_err_q  <= 1'b0;
    end else begin
      collision_err_q <= collision_err_d;
      overflow_err_q  <= overflow_err_d;
    end
  end

  alu_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign res_valid     = ~fifo_empty;
  assign res_data      = fifo_dout[DATA_WIDTH-1:0];
  assign res_tag       = fifo_dout[ENTRY_W-1 -: TAG_W];
  assign collision_err = collision_err_q;
  assign overflow_err  = overflow_err_q;
`ifdef ALU_COLLECT_PARITY_EN
  assign res_parity    = fifo_dout[FIFO_W-1];
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed scenarios plus randomized traffic vs a queue model.
module tb_alu_result_collector;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic          arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic [DW-1:0] res_data;
  logic [1:0]    res_tag;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [2:0]    fifo_level;
  logic          collision_err, overflow_err;
  logic          err_clr = 1'b0;
`ifdef ALU_COLLECT_PARITY_EN
  logic          res_parity;
`endif

  int vectors = 0;
  int errors  = 0;

  alu_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .arith_out     (arith_out),
    .arith_flag    (arith_flag),
    .logic_out     (logic_out),
    .logic_flag    (logic_flag),
    .cmp_out       (cmp_out),
    .cmp_flag      (cmp_flag),
    .shift_out     (shift_out),
    .shift_flag    (shift_flag),
    .res_data      (res_data),
    .res_tag       (res_tag),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .fifo_level    (fifo_level),
    .collision_err (collision_err),
    .overflow_err  (overflow_err),
    .err_clr       (err_clr)
`ifdef ALU_COLLECT_PARITY_EN
    ,.res_parity   (res_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of {tag, data} entries and the two sticky errors.
  logic [9:0] mq[$];
  logic       m_col = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic model_step();
    int         n;
    bit         pop, new_col, new_ovf;
    logic [9:0] e;
    if (rst) begin
      mq.delete();
      m_col = 1'b0;
      m_ovf = 1'b0;
    end else begin
      n = int'(arith_flag) + int'(logic_flag) + int'(cmp_flag) + int'(shift_flag);
      pop = (mq.size() > 0) && res_ready;
      new_col = (n > 1);
      new_ovf = (n > 0) && (mq.size() == DEPTH) && !pop;
      if (arith_flag)      e = {2'b00, arith_out};
      else if (logic_flag) e = {2'b01, logic_out};
      else if (cmp_flag)   e = {2'b10, cmp_out};
      else                 e = {2'b11, shift_out};
      if (pop) void'(mq.pop_front());
      if (n > 0 && !new_ovf) mq.push_back(e);
      if (err_clr) begin
        m_col = 1'b0;
        m_ovf = 1'b0;
      end
      m_col = m_col | new_col;
      m_ovf = m_ovf | new_ovf;
    end
  endtask

  function automatic logic [9:0] m_head();
    return (mq.size() > 0) ? mq[0] : 10'd0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arith_flag = 1'b0; logic_flag = 1'b0; cmp_flag = 1'b0; shift_flag = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    vectors++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", res_data); end
    vectors++; if (res_tag !== 2'b00) begin errors++; $display("FAIL reset_tag: got %b expected 00", res_tag); end
    vectors++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    vectors++; if ({collision_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {collision_err, overflow_err}); end
  endtask

  task automatic test_single();
    shift_flag = 1'b1; shift_out = 8'hA5; res_ready = 1'b1;
    tick();
    idle_inputs();
    vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", res_valid); end
    vectors++; if (res_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", res_data); end
    vectors++; if (res_tag !== 2'b11) begin errors++; $display("FAIL single_tag: got %b expected 11", res_tag); end
    tick();
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_collision();
    arith_flag = 1'b1; arith_out = 8'h11; cmp_flag = 1'b1; cmp_out = 8'h22;
    tick();
    idle_inputs();
    vectors++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL coll_level: got %0d expected 1", fifo_level); end
    vectors++; if (res_data !== 8'h11) begin errors++; $display("FAIL coll_data: got %h expected 11", res_data); end
    vectors++; if (res_tag !== 2'b00) begin errors++; $display("FAIL coll_tag: got %b expected 00", res_tag); end
    vectors++; if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_set: got %b expected 1", collision_err); end
    for (int i = 0; i < 3; i++) tick();
    vectors++; if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %b expected 1", collision_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (collision_err !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b expected 0", collision_err); end
    // New collision in the clearing cycle must win; drain at the same time.
    res_ready = 1'b1; err_clr = 1'b1; logic_flag = 1'b1; logic_out = 8'h33; shift_flag = 1'b1;
    tick();
    idle_inputs();
    vectors++; if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_clr_race: got %b expected 1", collision_err); end
    vectors++; if (res_data !== 8'h33) begin errors++; $display("FAIL coll_race_data: got %h expected 33", res_data); end
    tick();
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL coll_drain: got %b expected 0", res_valid); end
    err_clr = 1'b1;
    tick();
    idle_inputs();
    res_ready = 1'b0;
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h77;
    res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic_flag = 1'b1; logic_out = 8'(k);
      tick();
    end
    idle_inputs();
    vectors++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    vectors++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_err); end
    vectors++; if (res_data !== 8'h01) begin errors++; $display("FAIL ovf_head: got %h expected 01", res_data); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow_err); end
    logic_flag = 1'b1; logic_out = 8'h77; res_ready = 1'b1;
    tick();
    idle_inputs();
    res_ready = 1'b0;
    vectors++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpp_level: got %0d expected 4", fifo_level); end
    vectors++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fullpp_ovf: got %b expected 0", overflow_err); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (res_data !== exp_seq[k] || res_tag !== 2'b01) begin errors++; $display("FAIL drain_%0d: got %h/%b expected %h/01", k, res_data, res_tag, exp_seq[k]); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", res_valid); end
  endtask

  task automatic test_rst_midstream();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic_flag = 1'b1; logic_out = 8'(8'h40 + k);
      shift_flag = (k == 2);
      tick();
    end
    idle_inputs();
    rst = 1'b1; arith_flag = 1'b1; arith_out = 8'h99;
    tick();
    rst = 1'b0;
    idle_inputs();
    vectors++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
    vectors++; if ({collision_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b expected 00", {collision_err, overflow_err}); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_nodrain: got %b expected 0", res_valid); end
  endtask

`ifdef ALU_COLLECT_PARITY_EN
  task automatic test_parity();
    cmp_flag = 1'b1; cmp_out = 8'h03; res_ready = 1'b0;
    tick();
    idle_inputs();
    vectors++; if (res_parity !== 1'b1) begin errors++; $display("FAIL parity_cmp03: got %b expected 1", res_parity); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    int rdy_pct;
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0: rdy_pct = 80;
        1: rdy_pct = 25;
        2: rdy_pct = 60;
        default: rdy_pct = 10;
      endcase
      arith_flag = ($urandom_range(0, 4) == 0);
      logic_flag = ($urandom_range(0, 4) == 0);
      cmp_flag   = ($urandom_range(0, 4) == 0);
      shift_flag = ($urandom_range(0, 4) == 0);
      arith_out  = 8'($urandom);
      logic_out  = 8'($urandom);
      cmp_out    = 8'($urandom);
      shift_out  = 8'($urandom);
      res_ready  = ($urandom_range(0, 99) < rdy_pct);
      err_clr    = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
      vectors++; if (res_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, res_valid, mq.size() > 0); end
      vectors++; if ({res_tag, res_data} !== m_head()) begin errors++; $display("FAIL rnd_head[%0d]: got %h expected %h", i, {res_tag, res_data}, m_head()); end
      vectors++; if (int'(fifo_level) != mq.size()) begin errors++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, fifo_level, mq.size()); end
      vectors++; if ({collision_err, overflow_err} !== {m_col, m_ovf}) begin errors++; $display("FAIL rnd_errs[%0d]: got %b expected %b", i, {collision_err, overflow_err}, {m_col, m_ovf}); end
`ifdef ALU_COLLECT_PARITY_EN
      vectors++; if (res_parity !== ((mq.size() > 0) ? ^mq[0] : 1'b0)) begin errors++; $display("FAIL rnd_parity[%0d]: got %b", i, res_parity); end
`endif
    end
    rst = 1'b0;
    idle_inputs();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_overflow_and_full_pushpop();
    test_rst_midstream();
`ifdef ALU_COLLECT_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
